// File: rtl/ysyx_23060061_axil_sram_if.sv
// AXI4-Lite bus bundle between the core's bus master and the SRAM responder.
interface ysyx_23060061_axil_sram_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic [ADDR_W-1:0]   araddr;
  logic                arvalid;
  logic                arready;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rvalid;
  logic                rready;
  logic [ADDR_W-1:0]   awaddr;
  logic                awvalid;
  logic                awready;
  logic [DATA_W-1:0]   wdata;
  logic [DATA_W/8-1:0] wstrb;
  logic                wvalid;
  logic                wready;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready;

  modport master (
    output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );

  modport slave (
    input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
    output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
  );
endinterface

// File: rtl/ysyx_23060061_axil_sram.sv
// AXI4-Lite SRAM responder with independent read/write FSMs and programmable latency.
// Define YSYX_23060061_SRAM_RAND_DELAY_EN for LFSR-randomised latency in 1..LATENCY.
module ysyx_23060061_axil_sram #(
  parameter int              ADDR_W     = 32,
  parameter int              DATA_W     = 32,
  parameter int              DEPTH_LOG2 = 12,
  parameter logic [ADDR_W-1:0] BASE     = 32'h8000_0000,
  parameter int              LATENCY    = 2
) (
  input logic                      clk,
  input logic                      rst,
  ysyx_23060061_axil_sram_if.slave bus
);

  localparam int          WORDS    = 1 << DEPTH_LOG2;
  localparam logic [3:0]  CNT_INIT = 4'(LATENCY - 1);
  localparam logic [1:0]  RESP_OKAY   = 2'b00;
  localparam logic [1:0]  RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {R_IDLE = 2'd0, R_WAIT = 2'd1, R_RESP = 2'd2} r_state_e;
  typedef enum logic [1:0] {W_IDLE = 2'd0, W_WAIT = 2'd1, W_RESP = 2'd2} w_state_e;

  function automatic logic addr_ok(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] off;
    off = a - BASE;
    return (a >= BASE) && ((off >> (DEPTH_LOG2 + 2)) == {ADDR_W{1'b0}});
  endfunction

  function automatic logic [DEPTH_LOG2-1:0] word_idx(input logic [ADDR_W-1:0] a);
    logic [ADDR_W-1:0] off;
    off = a - BASE;
    return off[DEPTH_LOG2+1:2];
  endfunction

  logic [DATA_W-1:0] mem_r [0:WORDS-1];
  logic [3:0]        cnt_load_s;

`ifdef YSYX_23060061_SRAM_RAND_DELAY_EN
  localparam logic [3:0] LAT4 = 4'(LATENCY);
  logic [15:0] lfsr_r;

  // Free-running Galois LFSR, taps 16,14,13,11.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      lfsr_r <= 16'hACE1;
    end else begin
      lfsr_r <= {1'b0, lfsr_r[15:1]} ^ ({16{lfsr_r[0]}} & 16'hB400);
    end
  end

  assign cnt_load_s = lfsr_r[3:0] % LAT4;
`else
  assign cnt_load_s = CNT_INIT;
`endif

  // ---------------- read channel ----------------
  r_state_e          r_state_r, r_state_s;
  logic [3:0]        r_cnt_r, r_cnt_s;
  logic [ADDR_W-1:0] r_addr_r, r_addr_s;
  logic [DATA_W-1:0] rdata_r, rdata_s;
  logic [1:0]        rresp_r, rresp_s;
  logic              rvalid_r, rvalid_s;
  logic              arready_r, arready_s;

  // Read FSM state and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state_r <= R_IDLE;
      r_cnt_r   <= 4'd0;
      r_addr_r  <= {ADDR_W{1'b0}};
      rdata_r   <= {DATA_W{1'b0}};
      rresp_r   <= RESP_OKAY;
      rvalid_r  <= 1'b0;
      arready_r <= 1'b0;
    end else begin
      r_state_r <= r_state_s;
      r_cnt_r   <= r_cnt_s;
      r_addr_r  <= r_addr_s;
      rdata_r   <= rdata_s;
      rresp_r   <= rresp_s;
      rvalid_r  <= rvalid_s;
      arready_r <= arready_s;
    end
  end

  // Read FSM next state; the array is sampled before any same-cycle commit lands.
  always_comb begin
    r_state_s = r_state_r;
    r_cnt_s   = r_cnt_r;
    r_addr_s  = r_addr_r;
    rdata_s   = rdata_r;
    rresp_s   = rresp_r;
    rvalid_s  = rvalid_r;
    arready_s = arready_r;
    case (r_state_r)
      R_IDLE: begin
        if (bus.arvalid && arready_r) begin
          r_addr_s  = bus.araddr;
          r_cnt_s   = cnt_load_s;
          arready_s = 1'b0;
          r_state_s = R_WAIT;
        end else begin
          arready_s = 1'b1;
        end
      end
      R_WAIT: begin
        if (r_cnt_r == 4'd0) begin
          if (addr_ok(r_addr_r)) begin
            rdata_s = mem_r[word_idx(r_addr_r)];
            rresp_s = RESP_OKAY;
          end else begin
            rdata_s = {DATA_W{1'b0}};
            rresp_s = RESP_SLVERR;
          end
          rvalid_s  = 1'b1;
          r_state_s = R_RESP;
        end else begin
          r_cnt_s = r_cnt_r - 4'd1;
        end
      end
      R_RESP: begin
        if (rvalid_r && bus.rready) begin
          rvalid_s  = 1'b0;
          arready_s = 1'b1;
          r_state_s = R_IDLE;
        end else begin
          rvalid_s = 1'b1;
        end
      end
      default: begin
        rvalid_s  = 1'b0;
        arready_s = 1'b0;
        r_state_s = R_IDLE;
      end
    endcase
  end

  // ---------------- write channel ----------------
  w_state_e            w_state_r, w_state_s;
  logic [3:0]          w_cnt_r, w_cnt_s;
  logic [ADDR_W-1:0]   w_addr_r, w_addr_s;
  logic [DATA_W-1:0]   w_data_r, w_data_s;
  logic [DATA_W/8-1:0] w_strb_r, w_strb_s;
  logic                aw_held_r, aw_held_s;
  logic                w_held_r, w_held_s;
  logic                awready_r, awready_s;
  logic                wready_r, wready_s;
  logic [1:0]          bresp_r, bresp_s;
  logic                bvalid_r, bvalid_s;
  logic                aw_hs_s, w_hs_s, mem_we_s;
  logic [DEPTH_LOG2-1:0] w_idx_s;

  assign aw_hs_s = bus.awvalid && awready_r;
  assign w_hs_s  = bus.wvalid && wready_r;
  assign w_idx_s = word_idx(w_addr_r);

  // Write FSM state and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      w_state_r <= W_IDLE;
      w_cnt_r   <= 4'd0;
      w_addr_r  <= {ADDR_W{1'b0}};
      w_data_r  <= {DATA_W{1'b0}};
      w_strb_r  <= {(DATA_W/8){1'b0}};
      aw_held_r <= 1'b0;
      w_held_r  <= 1'b0;
      awready_r <= 1'b0;
      wready_r  <= 1'b0;
      bresp_r   <= RESP_OKAY;
      bvalid_r  <= 1'b0;
    end else begin
      w_state_r <= w_state_s;
      w_cnt_r   <= w_cnt_s;
      w_addr_r  <= w_addr_s;
      w_data_r  <= w_data_s;
      w_strb_r  <= w_strb_s;
      aw_held_r <= aw_held_s;
      w_held_r  <= w_held_s;
      awready_r <= awready_s;
      wready_r  <= wready_s;
      bresp_r   <= bresp_s;
      bvalid_r  <= bvalid_s;
    end
  end

  // Write FSM next state: AW and W are captured independently, then timed together.
  always_comb begin
    w_state_s = w_state_r;
    w_cnt_s   = w_cnt_r;
    w_addr_s  = w_addr_r;
    w_data_s  = w_data_r;
    w_strb_s  = w_strb_r;
    aw_held_s = aw_held_r;
    w_held_s  = w_held_r;
    awready_s = awready_r;
    wready_s  = wready_r;
    bresp_s   = bresp_r;
    bvalid_s  = bvalid_r;
    mem_we_s  = 1'b0;
    case (w_state_r)
      W_IDLE: begin
        if (aw_hs_s) begin
          w_addr_s  = bus.awaddr;
          aw_held_s = 1'b1;
        end else begin
          aw_held_s = aw_held_r;
        end
        if (w_hs_s) begin
          w_data_s = bus.wdata;
          w_strb_s = bus.wstrb;
          w_held_s = 1'b1;
        end else begin
          w_held_s = w_held_r;
        end
        awready_s = !(aw_held_r || aw_hs_s);
        wready_s  = !(w_held_r || w_hs_s);
        if ((aw_held_r || aw_hs_s) && (w_held_r || w_hs_s)) begin
          w_cnt_s   = cnt_load_s;
          w_state_s = W_WAIT;
        end else begin
          w_state_s = W_IDLE;
        end
      end
      W_WAIT: begin
        if (w_cnt_r == 4'd0) begin
          if (addr_ok(w_addr_r)) begin
            mem_we_s = 1'b1;
            bresp_s  = RESP_OKAY;
          end else begin
            mem_we_s = 1'b0;
            bresp_s  = RESP_SLVERR;
          end
          bvalid_s  = 1'b1;
          w_state_s = W_RESP;
        end else begin
          w_cnt_s = w_cnt_r - 4'd1;
        end
      end
      W_RESP: begin
        if (bvalid_r && bus.bready) begin
          bvalid_s  = 1'b0;
          aw_held_s = 1'b0;
          w_held_s  = 1'b0;
          awready_s = 1'b1;
          wready_s  = 1'b1;
          w_state_s = W_IDLE;
        end else begin
          bvalid_s = 1'b1;
        end
      end
      default: begin
        bvalid_s  = 1'b0;
        aw_held_s = 1'b0;
        w_held_s  = 1'b0;
        awready_s = 1'b0;
        wready_s  = 1'b0;
        w_state_s = W_IDLE;
      end
    endcase
  end

  // Byte-lane commit into the array; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we_s) begin
      for (int i = 0; i < DATA_W / 8; i++) begin
        if (w_strb_r[i]) begin
          mem_r[w_idx_s][8*i +: 8] <= w_data_r[8*i +: 8];
        end
      end
    end
  end

  assign bus.arready = arready_r;
  assign bus.rdata   = rdata_r;
  assign bus.rresp   = rresp_r;
  assign bus.rvalid  = rvalid_r;
  assign bus.awready = awready_r;
  assign bus.wready  = wready_r;
  assign bus.bresp   = bresp_r;
  assign bus.bvalid  = bvalid_r;

endmodule

// File: tb/tb_ysyx_23060061_axil_sram.sv
// Directed scoreboard bench for ysyx_23060061_axil_sram (LATENCY=2, DEPTH_LOG2=12).
module tb_ysyx_23060061_axil_sram;

  localparam int LAT = 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  ysyx_23060061_axil_sram_if bus();

  ysyx_23060061_axil_sram #(.LATENCY(LAT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;
  logic [33:0] rd_q[$];
  logic [1:0]  wr_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_lat(input string tag, input int n);
`ifdef YSYX_23060061_SRAM_RAND_DELAY_EN
    check(tag, 32'(n >= 1 && n <= LAT), 32'd1);
`else
    check(tag, 32'(n), 32'(LAT));
`endif
  endtask

  task automatic do_read(input string tag, input logic [31:0] addr,
                         input logic [31:0] exp_d, input logic [1:0] exp_r, input int bp);
    int n;
    logic [33:0] e;
    rd_q.push_back({exp_r, exp_d});
    bus.araddr  = addr;
    bus.arvalid = 1'b1;
    n = 0;
    while (!bus.arready && n < 20) begin step(); n++; end
    check({tag, ":arready"}, 32'(bus.arready), 32'd1);
    step();
    bus.arvalid = 1'b0;
    check({tag, ":arready_drop"}, 32'(bus.arready), 32'd0);
    n = 0;
    while (!bus.rvalid && n < 20) begin step(); n++; end
    check_lat({tag, ":r_lat"}, n);
    e = rd_q.pop_front();
    check({tag, ":rdata"}, bus.rdata, e[31:0]);
    check({tag, ":rresp"}, 32'(bus.rresp), 32'(e[33:32]));
    for (int i = 0; i < bp; i++) begin
      step();
      check({tag, ":bp_rvalid"}, 32'(bus.rvalid), 32'd1);
      check({tag, ":bp_rdata"}, bus.rdata, e[31:0]);
      check({tag, ":bp_arready"}, 32'(bus.arready), 32'd0);
    end
    bus.rready = 1'b1;
    step();
    bus.rready = 1'b0;
    check({tag, ":rvalid_clr"}, 32'(bus.rvalid), 32'd0);
    check({tag, ":arready_back"}, 32'(bus.arready), 32'd1);
  endtask

  // lead = cycles the W beat precedes AW (0 = same cycle).
  task automatic do_write(input string tag, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] strb, input logic [1:0] exp_r, input int lead);
    int n;
    wr_q.push_back(exp_r);
    bus.wdata  = data;
    bus.wstrb  = strb;
    bus.wvalid = 1'b1;
    bus.awaddr = addr;
    if (lead == 0) bus.awvalid = 1'b1;
    n = 0;
    while (!bus.wready && n < 20) begin step(); n++; end
    check({tag, ":wready"}, 32'(bus.wready), 32'd1);
    step();
    bus.wvalid  = 1'b0;
    bus.awvalid = 1'b0;
    check({tag, ":wready_drop"}, 32'(bus.wready), 32'd0);
    if (lead > 0) begin
      for (int i = 0; i < lead - 1; i++) begin
        step();
        check({tag, ":early_bvalid"}, 32'(bus.bvalid), 32'd0);
        check({tag, ":wready_low"}, 32'(bus.wready), 32'd0);
      end
      bus.awvalid = 1'b1;
      n = 0;
      while (!bus.awready && n < 20) begin step(); n++; end
      check({tag, ":awready"}, 32'(bus.awready), 32'd1);
      step();
      bus.awvalid = 1'b0;
      check({tag, ":awready_drop"}, 32'(bus.awready), 32'd0);
    end
    n = 0;
    while (!bus.bvalid && n < 20) begin step(); n++; end
    check_lat({tag, ":b_lat"}, n);
    check({tag, ":bresp"}, 32'(bus.bresp), 32'(wr_q.pop_front()));
    bus.bready = 1'b1;
    step();
    bus.bready = 1'b0;
    check({tag, ":bvalid_clr"}, 32'(bus.bvalid), 32'd0);
    check({tag, ":awready_back"}, 32'(bus.awready), 32'd1);
    check({tag, ":wready_back"}, 32'(bus.wready), 32'd1);
  endtask

  initial begin
    bus.araddr = 32'h0; bus.arvalid = 1'b0; bus.rready = 1'b0;
    bus.awaddr = 32'h0; bus.awvalid = 1'b0; bus.wdata = 32'h0;
    bus.wstrb = 4'h0; bus.wvalid = 1'b0; bus.bready = 1'b0;

    // Reset state
    repeat (3) step();
    check("rst:arready", 32'(bus.arready), 32'd0);
    check("rst:awready", 32'(bus.awready), 32'd0);
    check("rst:wready",  32'(bus.wready),  32'd0);
    check("rst:rvalid",  32'(bus.rvalid),  32'd0);
    check("rst:bvalid",  32'(bus.bvalid),  32'd0);
    check("rst:rdata",   bus.rdata,        32'h0);
    check("rst:rresp",   32'(bus.rresp),   32'd0);
    check("rst:bresp",   32'(bus.bresp),   32'd0);
    rst = 1'b1;
    check("rst_rel:arready_still0", 32'(bus.arready), 32'd0);
    step();
    check("rst_rel:arready", 32'(bus.arready), 32'd1);
    check("rst_rel:awready", 32'(bus.awready), 32'd1);
    check("rst_rel:wready",  32'(bus.wready),  32'd1);

    // Full-word round trip
    do_write("wr_full", 32'h8000_0010, 32'hDEAD_BEEF, 4'hF, 2'b00, 0);
    do_read("rd_full", 32'h8000_0010, 32'hDEAD_BEEF, 2'b00, 0);

    // Byte-lane merge
    do_write("wr_base", 32'h8000_0020, 32'h1122_3344, 4'hF, 2'b00, 0);
    do_write("wr_merge", 32'h8000_0020, 32'hAABB_CCDD, 4'b0101, 2'b00, 0);
    do_read("rd_merge", 32'h8000_0020, 32'h11BB_33DD, 2'b00, 0);

    // W beat three cycles before AW
    do_write("wr_w_first", 32'h8000_0000, 32'hCAFE_F00D, 4'hF, 2'b00, 3);
    do_read("rd_w_first", 32'h8000_0000, 32'hCAFE_F00D, 2'b00, 0);

    // Out of range on both sides of the window
    do_read("rd_below", 32'h7FFF_FFFC, 32'h0, 2'b10, 0);
    do_write("wr_above", 32'h8000_4000, 32'h5555_AAAA, 4'hF, 2'b10, 0);
    do_read("rd_word0", 32'h8000_0000, 32'hCAFE_F00D, 2'b00, 0);
    do_read("rd_above", 32'h8000_4000, 32'h0, 2'b10, 0);

    // Last word, low address bits ignored
    do_write("wr_last", 32'h8000_3FFC, 32'h0BAD_F00D, 4'hF, 2'b00, 0);
    do_read("rd_last", 32'h8000_3FFE, 32'h0BAD_F00D, 2'b00, 0);

    // wstrb = 0 changes nothing; read back under backpressure
    do_write("wr_nostrb", 32'h8000_0010, 32'h0123_4567, 4'h0, 2'b00, 0);
    do_read("rd_bp", 32'h8000_0010, 32'hDEAD_BEEF, 2'b00, 5);

    // Reset during R_WAIT
    bus.araddr  = 32'h8000_0010;
    bus.arvalid = 1'b1;
    step();
    bus.arvalid = 1'b0;
    step();
    rst = 1'b0;
    #1;
    check("rrst:arready_low", 32'(bus.arready), 32'd0);
    step();
    check("rrst:rvalid_in_rst", 32'(bus.rvalid), 32'd0);
    rst = 1'b1;
    check("rrst:arready_before_edge", 32'(bus.arready), 32'd0);
    step();
    check("rrst:arready_after_edge", 32'(bus.arready), 32'd1);
    for (int i = 0; i < 4; i++) begin
      check("rrst:no_rvalid", 32'(bus.rvalid), 32'd0);
      step();
    end

    // Reset with a write pending commit
    bus.awaddr  = 32'h8000_0010;
    bus.wdata   = 32'h0000_0000;
    bus.wstrb   = 4'hF;
    bus.awvalid = 1'b1;
    bus.wvalid  = 1'b1;
    step();
    bus.awvalid = 1'b0;
    bus.wvalid  = 1'b0;
    step();
    rst = 1'b0;
    step();
    rst = 1'b1;
    step();
    check("wrst:no_bvalid", 32'(bus.bvalid), 32'd0);
    check("wrst:awready", 32'(bus.awready), 32'd1);
    do_read("rd_after_wrst", 32'h8000_0010, 32'hDEAD_BEEF, 2'b00, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ysyx_23060061_axil_sram.md
Name: ysyx_23060061_axil_sram

Overview:
- AXI4-Lite memory responder (slave) that services core load/store and fetch requests once the core moves from direct DPI memory calls to a bus interface.
- Backed by an internal word-addressed SRAM array at base 0x8000_0000.
- Read and write channels are independent, each with a programmable response latency.
- Sits between the core's bus master and the simulation top.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width; fixed at 32, wstrb is 4 bits.
- DEPTH_LOG2, 12, log2 of the number of 32-bit words in the array.
- BASE, 32'h80000000, first byte address mapped.
- LATENCY, 2, cycles from request acceptance to response valid; legal range 1..15.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous, active-low reset (0 = reset)
- araddr  in  32  read address
- arvalid  in  1  read address valid
- arready  out  1  read address ready
- rdata  out  32  read data
- rresp  out  2  2'b00 OKAY, 2'b10 SLVERR
- rvalid  out  1  read data valid
- rready  in  1  read data ready
- awaddr  in  32  write address
- awvalid  in  1  write address valid
- awready  out  1  write address ready
- wdata  in  32  write data
- wstrb  in  4  byte enables
- wvalid  in  1  write data valid
- wready  out  1  write data ready
- bresp  out  2  write response
- bvalid  out  1  write response valid
- bready  in  1  write response ready

Behaviour:
- Reset (rst low, asynchronous): both FSMs go to IDLE. arready, awready, wready, rvalid, bvalid = 0; rdata = 0; rresp = bresp = 0; latency counters = 0. Array contents are not reset.
- The ready signals are registered. They rise on the first clk edge after rst goes high.
- Address decode:
  - Word index = (addr - BASE) >> 2; addr[1:0] are ignored.
  - In range iff BASE <= addr < BASE + 4*2^DEPTH_LOG2. Otherwise the access is an error.
- Read FSM, R_IDLE -> R_WAIT -> R_RESP:
  - R_IDLE: arready = 1. On arvalid & arready, latch araddr, drop arready next cycle, load cnt = LATENCY-1, go to R_WAIT.
  - R_WAIT: decrement cnt. When cnt == 0, sample the array (or the error result) into rdata/rresp, set rvalid, go to R_RESP.
  - Timing: handshake at edge t gives rvalid high after edge t+LATENCY.
  - R_RESP: rdata, rresp, rvalid are held stable until rvalid & rready. On that handshake, clear rvalid, raise arready, and return to R_IDLE. The next AR is accepted no earlier than the following cycle.
  - Error read: rdata = 0, rresp = 2'b10.
- Write FSM, W_IDLE -> W_WAIT -> W_RESP:
  - W_IDLE: awready and wready are each 1 until their own beat is captured.
  - AW and W may arrive in either order or in the same cycle. Each ready drops the cycle after its handshake.
  - Once both beats are held, load cnt = LATENCY-1 and go to W_WAIT.
  - W_WAIT: when cnt == 0, commit the write to the array, using only the byte lanes with wstrb[i] = 1, then set bvalid/bresp and go to W_RESP.
  - Error write: no array update, bresp = 2'b10.
  - W_RESP: hold until bvalid & bready, then clear bvalid, re-raise both readies, and return to W_IDLE.
  - wstrb = 0 is legal: no bytes change, bresp = OKAY.
- Simultaneous read sample and write commit to the same word in the same cycle: the read returns the old data.
- Both FSMs may be busy concurrently. Only one outstanding transaction per channel.
- Reset asserted mid-transaction: the in-flight transaction is dropped with no response. A write that has not yet committed leaves the array unchanged.

Optional Feature:
- Macro: YSYX_23060061_SRAM_RAND_DELAY_EN.
- Defined:
  - A 16-bit Galois LFSR (taps 16,14,13,11; seed 16'hACE1 at reset) advances every cycle.
  - Each accepted read or write loads cnt = {LFSR[3:0]} mod LATENCY + 0, so latency is random in 1..LATENCY.
  - All handshake rules are unchanged.
- Undefined: fixed latency of LATENCY cycles; no LFSR logic is synthesized.

Test Plan:
- Full-word round trip (LATENCY=2): write 0x80000010 / 0xDEADBEEF / wstrb=4'hF, then read 0x80000010 -> bvalid 2 cycles after the second beat, bresp 00; rvalid 2 cycles after AR, rdata 0xDEADBEEF, rresp 00.
- Byte-lane merge: word holds 0x11223344; write 0xAABBCCDD with wstrb=4'b0101, then read -> rdata 0x11BB33DD.
- W beat before AW: W beat 3 cycles before AW -> wready low after its handshake; commit and bvalid LATENCY cycles after the AW handshake.
- Out of range: read 0x7FFFFFFC -> rresp 10, rdata 0. Write to BASE + 4*2^DEPTH_LOG2 -> bresp 10; a later read of word 0 is unchanged.
- Read backpressure: rready held low for 5 cycles -> rvalid/rdata stable; arready stays 0 until the cycle after rready rises.
- Reset during R_WAIT: rst pulsed low for 1 cycle -> rvalid never asserted; arready returns to 1 on the first edge after rst rises. Same test with a pending write -> array unchanged.
